synapse_seq_array: RTL

Time-multiplexed, parametrised Hebbian synapse array for the oscillatory neural network. Each pass computes, for every neuron i, the signed sum over j≠i of ±w[i][j], where the sign follows a snapshot of the neuron outputs. It then drives nin[i] from the sign of that sum. Weights are held in an on-chip register array and loaded at run time through a write port. The block sits between the neuron oscillator bank (nout) and the neuron input stage (nin), and is paced by a start/done handshake.

---
 rtl/synapse_seq_array.sv | 97 +++++++++
 1 files changed

// File: rtl/synapse_seq_array.sv
// synapse_seq_array: time-multiplexed Hebbian synapse array; nin follows the sign of weighted sums over a nout snapshot
module synapse_seq_array #(
    parameter int NUM_NEURONS  = 15,
    parameter int WEIGHT_WIDTH = 5,
    parameter int ACC_WIDTH    = 10,
    localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_NEURONS-1:0]         nout,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_row,
    input  logic [ADDR_W-1:0]              wr_col,
    input  logic signed [WEIGHT_WIDTH-1:0] wr_data,
    output logic                           busy,
    output logic                           done,
    output logic                           wr_err,
    output logic [NUM_NEURONS-1:0]         nin
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE} state_t;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [NUM_NEURONS-1:0] snap_q, nin_q, nin_d;
    logic done_q, wr_err_q, wr_ok, wr_bad, launch, last_col;
    logic signed [WEIGHT_WIDTH-1:0] w_q [NUM_NEURONS][NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] acc_d [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] term [NUM_NEURONS];
    logic signed [ACC_WIDTH:0] sum [NUM_NEURONS];

    assign launch   = state_q == IDLE && start;
    assign last_col = col_q == ADDR_W'(NUM_NEURONS - 1);
    assign wr_ok    = wr_en && state_q == IDLE && 32'(wr_row) < NUM_NEURONS && 32'(wr_col) < NUM_NEURONS;
    assign wr_bad   = wr_en && !wr_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Next state: one column per ACCUM cycle, a single RESOLVE cycle, then back to IDLE
    always_comb begin
        state_d = state_q == IDLE  ? (start ? ACCUM : IDLE) :
                  state_q == ACCUM ? (last_col ? RESOLVE : ACCUM) : IDLE;
    end

    // Outputs: busy covers ACCUM and RESOLVE, everything else is registered
    always_comb begin
        busy   = state_q != IDLE;
        done   = done_q;
        wr_err = wr_err_q;
        nin    = nin_q;
    end

    // Per-row saturating accumulate of the current column, skipping the diagonal, and sign resolve
    always_comb begin
        col_d = launch ? '0 : state_q == ACCUM ? col_q + ADDR_W'(1) : col_q;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            term[i]  = snap_q[col_q] ? ACC_WIDTH'(w_q[i][col_q]) : -ACC_WIDTH'(w_q[i][col_q]);
            sum[i]   = {acc_q[i][ACC_WIDTH-1], acc_q[i]} + {term[i][ACC_WIDTH-1], term[i]};
            acc_d[i] = launch ? '0 :
                       (state_q == ACCUM && col_q != ADDR_W'(i)) ?
                       ((sum[i][ACC_WIDTH] != sum[i][ACC_WIDTH-1]) ? (sum[i][ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                                                   : sum[i][ACC_WIDTH-1:0]) :
                       acc_q[i];
            nin_d[i] = (state_q != RESOLVE || acc_q[i] == '0) ? nin_q[i] : !acc_q[i][ACC_WIDTH-1];
        end
    end

    // Datapath registers, weight array and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            snap_q   <= '0;
            nin_q    <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                acc_q[i] <= '0;
                for (int j = 0; j < NUM_NEURONS; j++) w_q[i][j] <= '0;
            end
        end else begin
            col_q    <= col_d;
            nin_q    <= nin_d;
            acc_q    <= acc_d;
            done_q   <= state_q == RESOLVE;
            wr_err_q <= wr_bad;
            if (launch) snap_q <= nout;
            if (wr_ok) w_q[wr_row][wr_col] <= wr_data;
        end
    end
endmodule
